// File: rtl/baej_pkg.sv
// Shared constants for the PC / RA / IR datapath: data width, reset PC,
// opcode encodings and the position of the op field inside an instruction.
// Pure declarations; no logic, no latency, no backpressure.
package baej_pkg;

  localparam int DATA_W = 16;
  localparam logic [DATA_W-1:0] RESET_PC = 16'h0000;

  // op field lives in the top nibble of every instruction word
  localparam int OP_MSB = 15;
  localparam int OP_LSB = 12;

  localparam logic [3:0] LDA = 4'd0;
  localparam logic [3:0] STA = 4'd1;
  localparam logic [3:0] ADD = 4'd2;
  localparam logic [3:0] SUB = 4'd3;
  localparam logic [3:0] LDI = 4'd4;
  localparam logic [3:0] BOP = 4'd5;
  localparam logic [3:0] CAL = 4'd6;
  localparam logic [3:0] RET = 4'd7;
  localparam logic [3:0] BEQ = 4'd8;
  localparam logic [3:0] BNE = 4'd9;
  localparam logic [3:0] LSL = 4'd10;
  localparam logic [3:0] LSR = 4'd11;
  localparam logic [3:0] CMP = 4'd12;
  localparam logic [3:0] NOT = 4'd13;
  localparam logic [3:0] ANR = 4'd14;
  localparam logic [3:0] ORR = 4'd15;

  // extract the op field from a 16-bit instruction word
  function automatic logic [3:0] get_op(input logic [15:0] word);
    return word[OP_MSB:OP_LSB];
  endfunction

endpackage

// File: rtl/pc_ra_unit_if.sv
// Bundle between the multicycle control unit (master) and the PC/RA/IR datapath (slave).
// Wires only; timing is set by the datapath registers (one cycle, op combinational).
// No backpressure: strobes are acted on in the cycle they are presented.
// Ports: master drives strobes, imm, ir_load, mem_rdata; slave drives pc, ra, inst, op,
//        stack_count and the two sticky stack flags.
interface pc_ra_unit_if #(
  parameter int DATA_W      = 16,
  parameter int STACK_DEPTH = 8
);

  logic                           writePC;
  logic                           PCsrc;
  logic                           ImRPC;
  logic                           writeRA;
  logic                           backup;
  logic                           restore;
  logic                           cmpeq;
  logic                           cmpne;
  logic                           eq;
  logic                           resetSig;
  logic [DATA_W-1:0]              imm;
  logic                           ir_load;
  logic [DATA_W-1:0]              mem_rdata;

  logic [DATA_W-1:0]              pc;
  logic [DATA_W-1:0]              ra;
  logic [DATA_W-1:0]              inst;
  logic [3:0]                     op;
  logic [$clog2(STACK_DEPTH):0]   stack_count;
  logic                           stack_overflow;
  logic                           stack_underflow;

  modport master (
    output writePC, PCsrc, ImRPC, writeRA, backup, restore,
           cmpeq, cmpne, eq, resetSig, imm, ir_load, mem_rdata,
    input  pc, ra, inst, op, stack_count, stack_overflow, stack_underflow
  );

  modport slave (
    input  writePC, PCsrc, ImRPC, writeRA, backup, restore,
           cmpeq, cmpne, eq, resetSig, imm, ir_load, mem_rdata,
    output pc, ra, inst, op, stack_count, stack_overflow, stack_underflow
  );

endinterface

// File: rtl/pc_ra_unit_ra_stack.sv
// Circular LIFO of saved return addresses with sticky overflow/underflow flags.
// Push/pop take effect at the next posedge; top is combinational from the array.
// Never stalls: push while full drops the oldest entry, pop while empty returns EMPTY_VAL.
// Ports: clk, Reset (sync active-low), clr (soft reset), push/pop/din, top, count, flags.
module ra_stack #(
  parameter int                DATA_W      = 16,
  parameter int                STACK_DEPTH = 8,
  parameter logic [DATA_W-1:0] EMPTY_VAL   = '0
) (
  input  logic                          clk,
  input  logic                          Reset,
  input  logic                          clr,
  input  logic                          push,
  input  logic                          pop,
  input  logic [DATA_W-1:0]             din,
  output logic [DATA_W-1:0]             top,
  output logic [$clog2(STACK_DEPTH):0]  count,
  output logic                          overflow,
  output logic                          underflow
);

  localparam int PW = $clog2(STACK_DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(STACK_DEPTH);

  logic [DATA_W-1:0] mem [STACK_DEPTH];
  logic [PW-1:0]     sp;        // next free slot; sp-1 is the top
  logic [PW-1:0]     top_idx;
  logic              empty;
  logic              full;

  assign top_idx = sp - 1'b1;
  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign top     = empty ? EMPTY_VAL : mem[top_idx];

  // Array write. Push+pop on a non-empty stack swaps the top in place.
  // When full, sp already points at the oldest entry, so a plain push
  // overwrites it and the window slides.
  always_ff @(posedge clk) begin
    if (Reset && !clr) begin
      if (push && pop && !empty)
        mem[top_idx] <= din;
      else if (push)
        mem[sp] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (!Reset || clr) begin
      sp        <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      unique case ({push, pop})
        2'b11: begin
          // empty swap: the pop underflows, the push still lands
          if (empty) begin
            sp        <= sp + 1'b1;
            count     <= count + 1'b1;
            underflow <= 1'b1;
          end
        end
        2'b10: begin
          sp <= sp + 1'b1;
          if (full) overflow <= 1'b1;
          else      count    <= count + 1'b1;
        end
        2'b01: begin
          if (empty) begin
            underflow <= 1'b1;
          end else begin
            sp    <= sp - 1'b1;
            count <= count - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/pc_ra_unit.sv
// PC, return-address and instruction-register datapath behind the control unit.
// PC/RA/IR update one cycle after the strobe; op is combinational from the IR.
// No backpressure: every strobe is honoured in the cycle it is presented.
// Ports: clk, Reset (sync active-low), bus (slave side of pc_ra_unit_if).
module pc_ra_unit #(
  parameter int                DATA_W      = baej_pkg::DATA_W,
  parameter int                STACK_DEPTH = 8,
  parameter logic [DATA_W-1:0] RESET_PC    = baej_pkg::RESET_PC
) (
  input  logic        clk,
  input  logic        Reset,
  pc_ra_unit_if.slave bus
);

  import baej_pkg::*;

  logic [DATA_W-1:0] pc_q;
  logic [DATA_W-1:0] ra_q;
  logic [DATA_W-1:0] inst_q;
  logic [DATA_W-1:0] pc_next;
  logic [DATA_W-1:0] ra_next;
  logic [DATA_W-1:0] pc_rel;
  logic [DATA_W-1:0] stack_top;
  logic              soft_rst;
  logic              take_branch;

  // soft reset only counts when the control unit is also writing the PC
  assign soft_rst    = bus.resetSig & bus.writePC;
  assign take_branch = (bus.cmpeq & bus.eq) | (bus.cmpne & ~bus.eq);
  assign pc_rel      = pc_q + (bus.imm << 1);

  ra_stack #(
    .DATA_W      (DATA_W),
    .STACK_DEPTH (STACK_DEPTH),
    .EMPTY_VAL   (RESET_PC)
  ) u_ra_stack (
    .clk       (clk),
    .Reset     (Reset),
    .clr       (soft_rst),
    .push      (bus.backup),
    .pop       (bus.restore),
    .din       (ra_q),
    .top       (stack_top),
    .count     (bus.stack_count),
    .overflow  (bus.stack_overflow),
    .underflow (bus.stack_underflow)
  );

  always_comb begin
    pc_next = pc_q;
    if (bus.writePC) begin
      if (bus.PCsrc)      pc_next = ra_q;
      else if (bus.ImRPC) pc_next = pc_rel;
      else                pc_next = pc_q + DATA_W'(2);
    end else if (take_branch) begin
      pc_next = pc_rel;
    end
  end

  // a pop on an empty stack yields RESET_PC through stack_top
  always_comb begin
    ra_next = ra_q;
    if (bus.writeRA) begin
      if (bus.restore) ra_next = stack_top;
      else             ra_next = pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!Reset) begin
      pc_q   <= RESET_PC;
      ra_q   <= '0;
      inst_q <= '0;
    end else begin
      if (soft_rst) begin
        pc_q <= RESET_PC;
        ra_q <= '0;
      end else begin
        pc_q <= pc_next;
        ra_q <= ra_next;
      end
      if (bus.ir_load) inst_q <= bus.mem_rdata;
    end
  end

  assign bus.pc   = pc_q;
  assign bus.ra   = ra_q;
  assign bus.inst = inst_q;
  assign bus.op   = inst_q[OP_MSB:OP_LSB];

endmodule

// File: tb/tb_pc_ra_unit.sv
module tb_pc_ra_unit;

  logic clk = 1'b0;
  logic Reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pc_ra_unit_if #(.DATA_W(16), .STACK_DEPTH(8)) bus ();

  pc_ra_unit #(
    .DATA_W      (16),
    .STACK_DEPTH (8),
    .RESET_PC    (16'h0000)
  ) dut (
    .clk   (clk),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.writePC  = 0; bus.PCsrc   = 0; bus.ImRPC = 0; bus.writeRA = 0;
    bus.backup   = 0; bus.restore = 0; bus.cmpeq = 0; bus.cmpne   = 0;
    bus.eq       = 0; bus.resetSig = 0; bus.imm = '0; bus.ir_load = 0;
    bus.mem_rdata = '0;
  endtask

  initial begin
    idle();
    Reset = 0;
    // reset dominates a live PC write
    bus.writePC = 1; bus.imm = 16'h0005;
    step(); step();
    chk("rst_pc",    bus.pc, 16'h0000);
    chk("rst_ra",    bus.ra, 16'h0000);
    chk("rst_inst",  bus.inst, 16'h0000);
    chk("rst_count", bus.stack_count, 0);
    chk("rst_ovf",   bus.stack_overflow, 0);
    chk("rst_udf",   bus.stack_underflow, 0);

    // sequential fetch with IR capture
    Reset = 1;
    idle();
    bus.writePC = 1; bus.ir_load = 1; bus.mem_rdata = 16'h4005;
    step();
    chk("seq_pc1", bus.pc, 16'h0002);
    chk("ir_inst", bus.inst, 16'h4005);
    chk("ir_op",   bus.op, 4'h4);
    bus.ir_load = 0;
    step();
    chk("seq_pc2", bus.pc, 16'h0004);
    step();
    chk("seq_pc3", bus.pc, 16'h0006);

    // set up pc=0010, ra=0100
    bus.ImRPC = 1; bus.imm = 16'h007D;      // 0006 + 00FA = 0100
    step();
    chk("jmp_pc", bus.pc, 16'h0100);
    idle(); bus.writeRA = 1;
    step();
    chk("ra_ld", bus.ra, 16'h0100);
    idle(); bus.writePC = 1; bus.ImRPC = 1; bus.imm = 16'hFF88;  // 0100 - 00F0
    step();
    chk("jmp_back", bus.pc, 16'h0010);

    // cal
    idle();
    bus.writePC = 1; bus.writeRA = 1; bus.ImRPC = 1; bus.backup = 1; bus.imm = 16'h0008;
    step();
    chk("cal_pc",  bus.pc, 16'h0020);
    chk("cal_ra",  bus.ra, 16'h0010);
    chk("cal_cnt", bus.stack_count, 1);
    // ret
    idle();
    bus.writePC = 1; bus.writeRA = 1; bus.PCsrc = 1; bus.restore = 1;
    step();
    chk("ret_pc",  bus.pc, 16'h0010);
    chk("ret_ra",  bus.ra, 16'h0100);
    chk("ret_cnt", bus.stack_count, 0);

    // branches from 0040
    idle(); bus.writePC = 1; bus.ImRPC = 1; bus.imm = 16'h0018;
    step();
    chk("br_setup", bus.pc, 16'h0040);
    idle(); bus.imm = 16'hFFFC; bus.cmpeq = 1; bus.eq = 1;
    step();
    chk("beq_taken", bus.pc, 16'h0038);
    bus.eq = 0;
    step();
    chk("beq_not", bus.pc, 16'h0038);
    bus.cmpeq = 0; bus.cmpne = 1; bus.eq = 0;
    step();
    chk("bne_taken", bus.pc, 16'h0030);

    // nine pushes: values 0100, 0030, 0032, ..., 003E
    idle();
    bus.backup = 1; bus.writeRA = 1; bus.writePC = 1;
    for (int i = 0; i < 9; i++) step();
    chk("ovf_cnt",  bus.stack_count, 8);
    chk("ovf_flag", bus.stack_overflow, 1);
    chk("ovf_udf",  bus.stack_underflow, 0);
    chk("ovf_ra",   bus.ra, 16'h0040);

    // eight pops give back the newest eight in reverse
    idle(); bus.writeRA = 1; bus.restore = 1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("pop%0d_ra", i), bus.ra, 16'h003E - 16'(2 * i));
    end
    chk("pop_cnt", bus.stack_count, 0);
    step();
    chk("udf_flag", bus.stack_underflow, 1);
    chk("udf_ra",   bus.ra, 16'h0000);
    chk("udf_cnt",  bus.stack_count, 0);

    // hard reset while pushing with three entries held
    idle(); bus.backup = 1;
    step(); step(); step();
    chk("pre_rst_cnt", bus.stack_count, 3);
    Reset = 0;
    step();
    chk("hrst_cnt", bus.stack_count, 0);
    chk("hrst_ovf", bus.stack_overflow, 0);
    chk("hrst_udf", bus.stack_underflow, 0);
    chk("hrst_pc",  bus.pc, 16'h0000);

    // soft reset keeps the IR
    Reset = 1;
    idle(); bus.writePC = 1; bus.ir_load = 1; bus.mem_rdata = 16'hA123;
    step();
    idle(); bus.writePC = 1; bus.writeRA = 1; bus.backup = 1;
    step();
    chk("pre_srst_pc",  bus.pc, 16'h0004);
    chk("pre_srst_ra",  bus.ra, 16'h0002);
    chk("pre_srst_cnt", bus.stack_count, 1);
    idle(); bus.writePC = 1; bus.resetSig = 1; bus.ImRPC = 1; bus.imm = 16'h0010;
    step();
    chk("srst_pc",   bus.pc, 16'h0000);
    chk("srst_ra",   bus.ra, 16'h0000);
    chk("srst_inst", bus.inst, 16'hA123);
    chk("srst_op",   bus.op, 4'hA);
    chk("srst_cnt",  bus.stack_count, 0);

    idle();
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
